mem_resp_queue: RTL and testbench

//  Parametrised MEM stage: holds up to DEPTH in-order instructions between pre_MEM and WB.

---
 rtl/mem_resp_queue_if.sv | 47 ++++
 rtl/mem_resp_queue.sv | 163 ++++++++++++++++
 tb/tb_mem_resp_queue.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_queue_if.sv
// Bundle of the MEM-stage pipeline handshakes, data-bus response, head entry, and forwarding taps.
// Handshakes: in_valid && ms_allowin enqueues; out_valid && ws_allowin dequeues.
interface mem_resp_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DEST_W = 5
);
    localparam int CW = $clog2(DEPTH + 1) + 1;

    logic                    ws_allowin;
    logic                    ms_allowin;
    logic                    in_valid;
    logic                    in_mem;
    logic                    in_load;
    logic [2:0]              in_load_op;
    logic [3:0]              in_rf_we;
    logic [DEST_W-1:0]       in_dest;
    logic [31:0]             in_result;
    logic                    in_ex;
    logic                    flush;
    logic                    data_data_ok;
    logic [31:0]             data_rdata;
    logic                    out_valid;
    logic [3:0]              out_rf_we;
    logic [DEST_W-1:0]       out_dest;
    logic [31:0]             out_result;
    logic                    out_ex;
    logic [DEPTH-1:0]        fwd_ready;
    logic [DEPTH*DEST_W-1:0] fwd_dest;
    logic [DEPTH*32-1:0]     fwd_data;
    logic                    resp_err;
    // Debug view of the stale-response cancel counter.
    logic [CW-1:0]           dbg_cancel_cnt;

    modport master (
        output ws_allowin, in_valid, in_mem, in_load, in_load_op, in_rf_we, in_dest,
               in_result, in_ex, flush, data_data_ok, data_rdata,
        input  ms_allowin, out_valid, out_rf_we, out_dest, out_result, out_ex,
               fwd_ready, fwd_dest, fwd_data, resp_err, dbg_cancel_cnt
    );

    modport slave (
        input  ws_allowin, in_valid, in_mem, in_load, in_load_op, in_rf_we, in_dest,
               in_result, in_ex, flush, data_data_ok, data_rdata,
        output ms_allowin, out_valid, out_rf_we, out_dest, out_result, out_ex,
               fwd_ready, fwd_dest, fwd_data, resp_err, dbg_cancel_cnt
    );
endinterface

// File: rtl/mem_resp_queue.sv
// MEM stage queue: in-order instructions waiting for in-order data-bus responses, with
// load extraction, WB-stall buffering, forwarding taps, and post-flush response cancelling.
module mem_resp_queue #(
    parameter int DEPTH  = 4,
    parameter int DEST_W = 5
) (
    input logic             clk,
    input logic             reset,
    mem_resp_queue_if.slave bus
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int CW   = $clog2(DEPTH + 1) + 1;

    logic [DEPTH-1:0]  e_vld, e_pend, e_got, e_load, e_ex;
    logic [2:0]        e_op   [DEPTH];
    logic [3:0]        e_we   [DEPTH];
    logic [DEST_W-1:0] e_dest [DEPTH];
    logic [31:0]       e_res  [DEPTH];

    logic [PW-1:0]   head, tail;
    logic [CNTW-1:0] count;
    logic [CW-1:0]   cancel_cnt, cancel_next;
    logic            resp_err_q;

    logic            data_ok_live, match_found, spurious;
    logic [PW-1:0]   match_phys;
    logic [CW-1:0]   outstanding;
    logic [31:0]     ext_data;
    logic [DEPTH-1:0] slot_done;
    logic [31:0]     slot_val [DEPTH];
    logic            out_valid, deq, enq, ms_allowin;

    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic [1:0] addr,
                                                 input logic [2:0] op);
        logic [7:0]  bval;
        logic [15:0] hval;
        bval = 8'(rdata >> {addr, 3'b000});
        hval = addr[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            3'd1:    return {{24{bval[7]}}, bval};
            3'd2:    return {24'h0, bval};
            3'd3:    return {{16{hval[15]}}, hval};
            3'd4:    return {16'h0, hval};
            default: return rdata;
        endcase
    endfunction

    // Responses owed to already-flushed instructions are swallowed before any matching.
    assign data_ok_live = bus.data_data_ok && (cancel_cnt == '0);

    always_comb begin
        logic [PW-1:0] idx;
        match_found = 1'b0;
        match_phys  = '0;
        outstanding = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx = head + PW'(i);
            if (e_vld[idx] && e_pend[idx] && !e_got[idx]) begin
                match_found = data_ok_live;
                match_phys  = idx;
                outstanding = outstanding + CW'(1);
            end
        end
    end

    assign spurious = data_ok_live && !match_found;
    assign ext_data = load_extract(bus.data_rdata, e_res[match_phys][1:0], e_op[match_phys]);

    always_comb begin
        for (int p = 0; p < DEPTH; p++) begin
            slot_done[p] = !e_pend[p] || e_got[p] || (match_found && match_phys == PW'(p));
            slot_val[p]  = (match_found && match_phys == PW'(p) && e_load[p]) ? ext_data : e_res[p];
        end
    end

    assign out_valid  = e_vld[head] && slot_done[head];
    assign deq        = out_valid && bus.ws_allowin;
    assign ms_allowin = !bus.flush && ((count != CNTW'(DEPTH)) || deq);
    assign enq        = bus.in_valid && ms_allowin;

    always_comb begin
        cancel_next = cancel_cnt - CW'(bus.data_data_ok && cancel_cnt != '0);
        if (bus.flush)
            cancel_next = cancel_next + outstanding - CW'(match_found);
    end

    assign bus.ms_allowin     = ms_allowin;
    assign bus.out_valid      = out_valid;
    assign bus.out_rf_we      = e_vld[head] ? e_we[head]     : 4'h0;
    assign bus.out_dest       = e_vld[head] ? e_dest[head]   : '0;
    assign bus.out_result     = e_vld[head] ? slot_val[head] : 32'h0;
    assign bus.out_ex         = e_vld[head] && e_ex[head];
    assign bus.resp_err       = resp_err_q;
    assign bus.dbg_cancel_cnt = cancel_cnt;

    // Forwarding taps are ordered by age, slot 0 being the head.
    always_comb begin
        logic [PW-1:0] idx;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            bus.fwd_ready[i]                  = e_vld[idx] && slot_done[idx];
            bus.fwd_dest[i*DEST_W +: DEST_W]  = e_vld[idx] ? e_dest[idx] : '0;
            bus.fwd_data[i*32 +: 32]          = e_vld[idx] ? slot_val[idx] : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_vld      <= '0;
            e_pend     <= '0;
            e_got      <= '0;
            e_load     <= '0;
            e_ex       <= '0;
            for (int p = 0; p < DEPTH; p++) begin
                e_op[p]   <= '0;
                e_we[p]   <= '0;
                e_dest[p] <= '0;
                e_res[p]  <= '0;
            end
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            cancel_cnt <= '0;
            resp_err_q <= 1'b0;
        end else begin
            cancel_cnt <= cancel_next;
            if (spurious)
                resp_err_q <= 1'b1;
            if (bus.flush) begin
                e_vld <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (match_found) begin
                    e_got[match_phys] <= 1'b1;
                    if (e_load[match_phys])
                        e_res[match_phys] <= ext_data;
                end
                if (deq) begin
                    e_vld[head] <= 1'b0;
                    head        <= head + PW'(1);
                end
                // Enqueue last: when full, the freed head slot is reused as the new tail.
                if (enq) begin
                    e_vld[tail]  <= 1'b1;
                    e_pend[tail] <= bus.in_mem && !bus.in_ex;
                    e_got[tail]  <= 1'b0;
                    e_load[tail] <= bus.in_load;
                    e_ex[tail]   <= bus.in_ex;
                    e_op[tail]   <= bus.in_load_op;
                    e_we[tail]   <= bus.in_load ? ((bus.in_rf_we != 4'h0) ? 4'hf : 4'h0) : bus.in_rf_we;
                    e_dest[tail] <= bus.in_dest;
                    e_res[tail]  <= bus.in_result;
                    tail         <= tail + PW'(1);
                end
                count <= count + CNTW'(enq) - CNTW'(deq);
            end
        end
    end
endmodule

// File: tb/tb_mem_resp_queue.sv
// Bench for mem_resp_queue: directed scenarios plus random traffic, all checked against a
// queue-of-entries reference model.
module tb_mem_resp_queue;
  localparam int DEPTH  = 4;
  localparam int DEST_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_resp_queue_if #(.DEPTH(DEPTH), .DEST_W(DEST_W)) bus ();
  mem_resp_queue #(.DEPTH(DEPTH), .DEST_W(DEST_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit pend; bit got; bit load; bit ex;
    bit [2:0] op; bit [3:0] we; bit [DEST_W-1:0] dest; bit [31:0] val;
  } ent_t;

  ent_t mq[$];
  int   m_cancel;
  bit   m_err;
  int   m_match;
  bit   m_drop, m_spur, e_out_valid, e_allowin;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] ref_ext(input bit [31:0] rd, input bit [1:0] a, input bit [2:0] op);
    longint b, h;
    b = (longint'(rd) / (longint'(1) << (8 * a))) % 256;
    h = (longint'(rd) / (longint'(1) << (16 * a[1]))) % 65536;
    case (op)
      3'd1: return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd2: return 32'(b);
      3'd3: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd4: return 32'(h);
      default: return rd;
    endcase
  endfunction

  function automatic int m_outstanding();
    int n = 0;
    foreach (mq[i]) if (mq[i].pend && !mq[i].got) n++;
    return n;
  endfunction

  function automatic bit m_done(input int i);
    return !mq[i].pend || mq[i].got || (m_match == i);
  endfunction

  function automatic bit [31:0] m_final(input int i);
    if (m_match == i && mq[i].load) return ref_ext(bus.data_rdata, mq[i].val[1:0], mq[i].op);
    return mq[i].val;
  endfunction

  // Evaluate the model against the inputs currently driven and compare every output.
  task automatic model_check();
    bit rdy;
    m_drop = 0; m_spur = 0; m_match = -1;
    if (bus.data_data_ok) begin
      if (m_cancel > 0) m_drop = 1;
      else begin
        foreach (mq[i]) if (m_match < 0 && mq[i].pend && !mq[i].got) m_match = i;
        if (m_match < 0) m_spur = 1;
      end
    end
    e_out_valid = (mq.size() > 0) && m_done(0);
    e_allowin = !bus.flush && (mq.size() < DEPTH || (e_out_valid && bus.ws_allowin));
    check("out_valid", 64'(bus.out_valid), 64'(e_out_valid));
    check("ms_allowin", 64'(bus.ms_allowin), 64'(e_allowin));
    check("resp_err", 64'(bus.resp_err), 64'(m_err));
    check("cancel_cnt", 64'(bus.dbg_cancel_cnt), 64'(m_cancel));
    if (e_out_valid) begin
      check("out_result", 64'(bus.out_result), 64'(m_final(0)));
      check("out_dest", 64'(bus.out_dest), 64'(mq[0].dest));
      check("out_rf_we", 64'(bus.out_rf_we), 64'(mq[0].we));
      check("out_ex", 64'(bus.out_ex), 64'(mq[0].ex));
    end
    for (int i = 0; i < DEPTH; i++) begin
      rdy = (i < mq.size()) && m_done(i);
      check($sformatf("fwd_ready[%0d]", i), 64'(bus.fwd_ready[i]), 64'(rdy));
      check($sformatf("fwd_dest[%0d]", i), 64'(bus.fwd_dest[i*DEST_W +: DEST_W]),
            (i < mq.size()) ? 64'(mq[i].dest) : 64'd0);
      if (rdy) check($sformatf("fwd_data[%0d]", i), 64'(bus.fwd_data[i*32 +: 32]), 64'(m_final(i)));
    end
  endtask

  task automatic model_update();
    ent_t e;
    if (bus.flush) begin
      m_cancel = m_cancel - int'(m_drop) + m_outstanding() - ((m_match >= 0) ? 1 : 0);
      mq.delete();
    end else begin
      if (m_match >= 0) begin
        if (mq[m_match].load) mq[m_match].val = ref_ext(bus.data_rdata, mq[m_match].val[1:0], mq[m_match].op);
        mq[m_match].got = 1;
      end
      if (e_out_valid && bus.ws_allowin) void'(mq.pop_front());
      if (bus.in_valid && e_allowin) begin
        e.pend = bus.in_mem && !bus.in_ex; e.got = 0; e.load = bus.in_load; e.ex = bus.in_ex;
        e.op = bus.in_load_op; e.dest = bus.in_dest; e.val = bus.in_result;
        e.we = bus.in_load ? ((bus.in_rf_we != 0) ? 4'hf : 4'h0) : bus.in_rf_we;
        mq.push_back(e);
      end
      m_cancel = m_cancel - int'(m_drop);
    end
    if (m_spur) m_err = 1;
  endtask

  task automatic drive(input bit v, input bit mem, input bit load, input bit [2:0] op,
                       input bit [3:0] we, input bit [DEST_W-1:0] dest, input bit [31:0] res,
                       input bit ex, input bit fl, input bit ok, input bit [31:0] rd, input bit wsa);
    @(negedge clk);
    bus.in_valid = v; bus.in_mem = mem; bus.in_load = load; bus.in_load_op = op;
    bus.in_rf_we = we; bus.in_dest = dest; bus.in_result = res; bus.in_ex = ex;
    bus.flush = fl; bus.data_data_ok = ok; bus.data_rdata = rd; bus.ws_allowin = wsa;
    #1 model_check();
  endtask

  // Short forms: cyc() drives and checks a cycle, tick() commits it.
  task automatic cyc(input bit v, input bit mem, input bit load, input bit [2:0] op,
                     input bit [31:0] res, input bit fl, input bit ok, input bit [31:0] rd, input bit wsa);
    drive(v, mem, load, op, 4'h3, DEST_W'(res + 1), res, 1'b0, fl, ok, rd, wsa);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic step(input bit v, input bit mem, input bit load, input bit [2:0] op,
                      input bit [31:0] res, input bit fl, input bit ok, input bit [31:0] rd, input bit wsa);
    cyc(v, mem, load, op, res, fl, ok, rd, wsa);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 0; bus.in_mem = 0; bus.in_load = 0; bus.in_load_op = 0; bus.in_rf_we = 0;
    bus.in_dest = 0; bus.in_result = 0; bus.in_ex = 0; bus.flush = 0; bus.data_data_ok = 0;
    bus.data_rdata = 0; bus.ws_allowin = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete(); m_cancel = 0; m_err = 0;
  endtask

  initial begin
    int out;
    bit ok;
    do_reset();

    // Reset state.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ms_allowin", 64'(bus.ms_allowin), 64'd1);
    check("rst_resp_err", 64'(bus.resp_err), 64'd0);
    check("rst_out_result", 64'(bus.out_result), 64'd0);
    check("rst_fwd_dest", 64'(bus.fwd_dest), 64'd0);
    tick();

    // ALU-only back-to-back.
    step(1, 0, 0, 0, 100, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 200, 0, 0, 0, 1); check("alu_seq0", 64'(bus.out_result), 64'd100); tick();
    cyc(1, 0, 0, 0, 300, 0, 0, 0, 1); check("alu_seq1", 64'(bus.out_result), 64'd200); tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);   check("alu_seq2", 64'(bus.out_result), 64'd300); tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Pipelined loads.
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 32'h1000 + 32'(4 * i), 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 5, 0, 0, 0, 1);
    check("full_allowin", 64'(bus.ms_allowin), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 32'(11 * (i + 1)), 1);
      check("pipe_result", 64'(bus.out_result), 64'(11 * (i + 1)));
      tick();
    end

    // Extension with the response bypassed straight to WB.
    step(1, 1, 1, 3'd1, 32'h2003, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000, 1);
    check("lb_ext", 64'(bus.out_result), 64'hFFFF_FF80);
    check("lb_we", 64'(bus.out_rf_we), 64'hf);
    tick();
    step(1, 1, 1, 3'd4, 32'h2002, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000, 1);
    check("lhu_ext", 64'(bus.out_result), 64'h0000_80FF);
    tick();

    // WB stall retains returned data.
    step(1, 1, 1, 0, 32'h40, 0, 0, 0, 0);
    step(1, 1, 1, 0, 32'h44, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'hAAAA_0001, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'hBBBB_0002, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); check("stall_hold", 64'(bus.out_result), 64'hAAAA_0001); tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1); check("stall_rel0", 64'(bus.out_result), 64'hAAAA_0001); tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1); check("stall_rel1", 64'(bus.out_result), 64'hBBBB_0002); tick();

    // Flush with 3 pending and a response in the same cycle.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 32'h80 + 32'(4 * i), 0, 0, 0, 1);
    step(1, 0, 0, 0, 9, 1, 1, 32'hDEAD_0000, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("flush_cancel", 64'(bus.dbg_cancel_cnt), 64'd2);
    check("flush_empty", 64'(bus.fwd_dest), 64'd0);
    tick();
    step(1, 1, 1, 0, 32'h90, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h1111_1111, 1); check("drop0", 64'(bus.out_valid), 64'd0); tick();
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h2222_2222, 1); check("drop1", 64'(bus.out_valid), 64'd0); tick();
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 1);
    check("post_flush_fill", 64'(bus.out_result), 64'h1234_5678);
    check("post_flush_valid", 64'(bus.out_valid), 64'd1);
    tick();

    // Spurious response on an empty queue.
    step(0, 0, 0, 0, 0, 0, 1, 32'h5555_5555, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("spur_err", 64'(bus.resp_err), 64'd1);
    check("spur_empty", 64'(bus.out_valid), 64'd0);
    tick();
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("err_cleared", 64'(bus.resp_err), 64'd0);
    tick();

    // Random traffic; responses only when one is owed.
    for (int c = 0; c < 1500; c++) begin
      out = m_outstanding() + m_cancel;
      ok = (out > 0) && ($urandom_range(0, 99) < 45);
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), DEST_W'($urandom),
            32'($urandom), $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3,
            ok, 32'($urandom), $urandom_range(0, 99) < 70);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
